// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings, default widths
// and the round-robin successor helper.
package dmem_pkg;

  localparam int DMEM_AW = 16;
  localparam int DMEM_DW = 32;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // Round-robin successor: the port that did not own the RAM last; A after IDLE.
  function automatic owner_e rr_pick(input owner_e last);
    owner_e nxt;
    case (last)
      OWN_A:   nxt = OWN_B;
      OWN_B:   nxt = OWN_A;
      default: nxt = OWN_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: level request, command and
// address/data in, combinational grant and registered read return out.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
);

  logic          req;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output req, rw, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, rw, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles a requester lost arbitration; `starved`
// flags that it must win the next time it asks.
module dmem_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic starved
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

  logic [CW-1:0] cnt_r;

  // Hold wins over clear so a RAM miss leaves the count untouched.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_r <= '0;
    end else if (hold) begin
      cnt_r <= cnt_r;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign starved = (cnt_r == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: port A is the pipeline
// MEM stage, port B the loader/debug master with burst lock and starvation guard.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  dmem_arbiter_if.slave port_a,
  dmem_arbiter_if.slave port_b,
  input  logic          b_lock,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_miss,
  output logic          busy
);

  owner_e        owner_r;
  owner_e        win_s;
  logic          a_starved_s;
  logic          b_starved_s;
  logic          a_gnt_s;
  logic          b_gnt_s;
  logic          sel_rw_s;
  logic          hold_s;
  logic          a_rvalid_r;
  logic          b_rvalid_r;
  logic [DW-1:0] a_rdata_r;
  logic [DW-1:0] b_rdata_r;

  // Winner selection; starvation outranks the B burst lock.
  always_comb begin
    win_s = OWN_IDLE;
    if (!Rst) begin
      win_s = OWN_IDLE;
    end else if (port_b.req && b_starved_s) begin
      win_s = OWN_B;
    end else if (port_a.req && a_starved_s) begin
      win_s = OWN_A;
    end else if ((owner_r == OWN_B) && b_lock && port_b.req) begin
      win_s = OWN_B;
    end else if (port_a.req && !port_b.req) begin
      win_s = OWN_A;
    end else if (!port_a.req && port_b.req) begin
      win_s = OWN_B;
    end else if (port_a.req && port_b.req) begin
      if (RR_MODE != 0) begin
        win_s = rr_pick(owner_r);
      end else begin
        win_s = OWN_A;
      end
    end else begin
      win_s = OWN_IDLE;
    end
  end

  // RAM-side mux; the enable stays up on a miss so the RAM sees the retry.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sel_rw_s  = 1'b0;
    case (win_s)
      OWN_A: begin
        mem_en    = 1'b1;
        mem_addr  = port_a.addr;
        mem_wdata = port_a.wdata;
        sel_rw_s  = port_a.rw;
      end
      OWN_B: begin
        mem_en    = 1'b1;
        mem_addr  = port_b.addr;
        mem_wdata = port_b.wdata;
        sel_rw_s  = port_b.rw;
      end
      default: begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        sel_rw_s  = 1'b0;
      end
    endcase
  end

  assign a_gnt_s = (win_s == OWN_A) & ~mem_miss;
  assign b_gnt_s = (win_s == OWN_B) & ~mem_miss;
  assign mem_rw  = sel_rw_s & ~mem_miss;
  assign busy    = a_gnt_s | b_gnt_s;
  assign hold_s  = mem_en & mem_miss;

  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve_a (
    .Clk     (Clk),
    .Rst     (Rst),
    .inc     (port_a.req & b_gnt_s),
    .clr     (a_gnt_s | ~port_a.req),
    .hold    (hold_s),
    .starved (a_starved_s)
  );

  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve_b (
    .Clk     (Clk),
    .Rst     (Rst),
    .inc     (port_b.req & a_gnt_s),
    .clr     (b_gnt_s | ~port_b.req),
    .hold    (hold_s),
    .starved (b_starved_s)
  );

  // Owner FSM: remembers the last successfully granted port, never returns to IDLE.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      owner_r <= OWN_IDLE;
    end else if (a_gnt_s || b_gnt_s) begin
      case (win_s)
        OWN_A:   owner_r <= OWN_A;
        OWN_B:   owner_r <= OWN_B;
        default: owner_r <= owner_r;
      endcase
    end else begin
      owner_r <= owner_r;
    end
  end

  // Read return: capture RAM data at the grant edge, strobe valid for one cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rdata_r  <= '0;
      b_rdata_r  <= '0;
    end else begin
      a_rvalid_r <= a_gnt_s & ~port_a.rw;
      b_rvalid_r <= b_gnt_s & ~port_b.rw;
      if (a_gnt_s && !port_a.rw) begin
        a_rdata_r <= mem_rdata;
      end else begin
        a_rdata_r <= a_rdata_r;
      end
      if (b_gnt_s && !port_b.rw) begin
        b_rdata_r <= mem_rdata;
      end else begin
        b_rdata_r <= b_rdata_r;
      end
    end
  end

  assign port_a.gnt    = a_gnt_s;
  assign port_a.rvalid = a_rvalid_r;
  assign port_a.rdata  = a_rdata_r;
  assign port_b.gnt    = b_gnt_s;
  assign port_b.rvalid = b_rvalid_r;
  assign port_b.rdata  = b_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a fixed-priority and a round-robin instance driven with the
// same stimulus, each checked every cycle against a behavioural model plus gnt tables.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int SMAX = 4;

  typedef struct {
    logic        rst;
    logic        a_req;
    logic        a_rw;
    logic [15:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_rw;
    logic [15:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_lock;
    logic        miss;
    logic        chk;
    logic [1:0]  g0;   // expected {a_gnt,b_gnt}, fixed-priority instance
    logic [1:0]  g1;   // expected {a_gnt,b_gnt}, round-robin instance
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_rw = 1'b0, b_req = 1'b0, b_rw = 1'b0;
  logic [15:0] a_addr = 16'h0, b_addr = 16'h0;
  logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;
  logic        b_lock = 1'b0, miss = 1'b0;

  logic [1:0]  o_agnt, o_bgnt, o_arv, o_brv, o_men, o_mrw, o_busy;
  logic [31:0] o_ard [2];
  logic [31:0] o_brd [2];
  logic [31:0] o_mwd [2];
  logic [15:0] o_maddr [2];

  for (genvar g = 0; g < 2; g++) begin : inst
    dmem_arbiter_if ia ();
    dmem_arbiter_if ib ();
    logic        men, mrw, busy;
    logic [15:0] maddr;
    logic [31:0] mwd, mrd;
    logic [31:0] ram [256] = '{default: 32'h0};
    int          wcnt8 = 0;

    assign ia.req = a_req;  assign ia.rw = a_rw;  assign ia.addr = a_addr;  assign ia.wdata = a_wdata;
    assign ib.req = b_req;  assign ib.rw = b_rw;  assign ib.addr = b_addr;  assign ib.wdata = b_wdata;
    assign mrd = ram[maddr[7:0]];

    dmem_arbiter #(.AW(16), .DW(32), .RR_MODE(g), .STARVE_MAX(SMAX)) dut (
      .Clk(clk), .Rst(rst), .port_a(ia), .port_b(ib), .b_lock(b_lock),
      .mem_en(men), .mem_rw(mrw), .mem_addr(maddr), .mem_wdata(mwd),
      .mem_rdata(mrd), .mem_miss(miss), .busy(busy)
    );

    always @(posedge clk) begin
      if (men && mrw) begin
        ram[maddr[7:0]] <= mwd;
        if (maddr == 16'h0008) wcnt8 <= wcnt8 + 1;
      end
    end

    assign o_agnt[g] = ia.gnt;    assign o_bgnt[g] = ib.gnt;
    assign o_arv[g]  = ia.rvalid; assign o_brv[g]  = ib.rvalid;
    assign o_ard[g]  = ia.rdata;  assign o_brd[g]  = ib.rdata;
    assign o_men[g]  = men;       assign o_mrw[g]  = mrw;   assign o_busy[g] = busy;
    assign o_maddr[g] = maddr;    assign o_mwd[g]  = mwd;
  end

  // Reference model state, per instance (index = RR_MODE)
  int          cnt [2][2];
  int          own [2];
  logic        rvm [2][2];
  logic [31:0] rdm [2][2];
  logic [31:0] shadow [2][256];

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
  endtask

  task automatic model_reset(input int k);
    own[k] = 0;
    for (int p = 0; p < 2; p++) begin
      cnt[k][p] = 0;
      rvm[k][p] = 1'b0;
      rdm[k][p] = 32'h0;
    end
  endtask

  // Winner per the arbitration rules: 0 none, 1 A, 2 B.
  function automatic int pick(input int k, input vec_t v);
    if (!v.rst) return 0;
    if (v.b_req && cnt[k][1] >= SMAX) return 2;
    if (v.a_req && cnt[k][0] >= SMAX) return 1;
    if (own[k] == 2 && v.b_lock && v.b_req) return 2;
    if (v.a_req && v.b_req) return (k == 1 && own[k] == 1) ? 2 : 1;
    if (v.a_req) return 1;
    if (v.b_req) return 2;
    return 0;
  endfunction

  task automatic check_model(input int k, input vec_t v);
    int          w;
    logic        ga, gb, en, rw, erva, ervb;
    logic [15:0] ad;
    logic [31:0] wd, erda, erdb;
    w  = pick(k, v);
    ga = (w == 1) && !v.miss;
    gb = (w == 2) && !v.miss;
    en = (w != 0);
    rw = ((w == 1) ? v.a_rw : (w == 2) ? v.b_rw : 1'b0) && !v.miss;
    ad = (w == 1) ? v.a_addr : (w == 2) ? v.b_addr : 16'h0;
    wd = (w == 1) ? v.a_wdata : (w == 2) ? v.b_wdata : 32'h0;
    erva = v.rst ? rvm[k][0] : 1'b0;
    ervb = v.rst ? rvm[k][1] : 1'b0;
    erda = v.rst ? rdm[k][0] : 32'h0;
    erdb = v.rst ? rdm[k][1] : 32'h0;
    chk("ctl_gnt_en_rw_busy", k, {o_agnt[k], o_bgnt[k], o_men[k], o_mrw[k], o_busy[k]}, {ga, gb, en, rw, ga | gb});
    chk("mem_addr_wdata", k, {o_maddr[k], o_mwd[k]}, {ad, wd});
    chk("rvalid", k, {o_arv[k], o_brv[k]}, {erva, ervb});
    chk("a_rdata", k, o_ard[k], erda);
    chk("b_rdata", k, o_brd[k], erdb);
  endtask

  task automatic commit(input int k, input vec_t v);
    int         w;
    logic       req [2];
    logic       rwv;
    logic [7:0] ix;
    if (!v.rst) begin
      model_reset(k);
      return;
    end
    w = pick(k, v);
    req[0] = v.a_req;
    req[1] = v.b_req;
    rvm[k][0] = 1'b0;
    rvm[k][1] = 1'b0;
    if (w != 0 && v.miss) return;
    if (w != 0) begin
      rwv = (w == 1) ? v.a_rw : v.b_rw;
      ix  = (w == 1) ? v.a_addr[7:0] : v.b_addr[7:0];
      if (rwv) shadow[k][ix] = (w == 1) ? v.a_wdata : v.b_wdata;
      else begin
        rvm[k][w-1] = 1'b1;
        rdm[k][w-1] = shadow[k][ix];
      end
      own[k] = w;
    end
    for (int p = 0; p < 2; p++) begin
      if (w == p + 1 || !req[p]) cnt[k][p] = 0;
      else if (w != 0) cnt[k][p] = (cnt[k][p] + 1 > SMAX) ? SMAX : cnt[k][p] + 1;
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst;  miss = v.miss;  b_lock = v.b_lock;
    a_req = v.a_req;  a_rw = v.a_rw;  a_addr = v.a_addr;  a_wdata = v.a_wdata;
    b_req = v.b_req;  b_rw = v.b_rw;  b_addr = v.b_addr;  b_wdata = v.b_wdata;
    #3;
    for (int k = 0; k < 2; k++) begin
      check_model(k, v);
      if (v.chk) chk("table_gnt", k, {o_agnt[k], o_bgnt[k]}, (k == 0) ? v.g0 : v.g1);
      commit(k, v);
    end
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  function automatic vec_t mk(input logic r, ar, arw, input logic [15:0] aad, input logic [31:0] awd,
                              input logic br, brw, input logic [15:0] bad, input logic [31:0] bwd,
                              input logic lk, ms, input logic [1:0] g0, g1);
    vec_t v;
    v.rst = r;  v.a_req = ar;  v.a_rw = arw;  v.a_addr = aad;  v.a_wdata = awd;
    v.b_req = br;  v.b_rw = brw;  v.b_addr = bad;  v.b_wdata = bwd;
    v.b_lock = lk;  v.miss = ms;  v.chk = 1'b1;  v.g0 = g0;  v.g1 = g1;
    return v;
  endfunction

  localparam logic [1:0] GA = 2'b10, GB = 2'b01, GN = 2'b00;

  initial begin
    vec_t tbl [$];
    vec_t rst_v, idle_v, r;

    model_reset(0);
    model_reset(1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) shadow[k][i] = 32'h0;

    rst_v  = mk(1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GN, GN);
    idle_v = mk(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, GN, GN);

    // Reset state: requests high but nothing granted, outputs cleared
    for (int i = 0; i < 3; i++) step(rst_v);

    // A-only write then read-back
    step(mk(1'b1, 1'b1, 1'b1, 16'h0004, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, GA, GA));
    step(mk(1'b1, 1'b1, 1'b0, 16'h0004, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, GA, GA));
    step(idle_v);
    for (int k = 0; k < 2; k++) begin
      chk("aonly_rvalid", k, o_arv[k], 1'b1);
      chk("aonly_rdata", k, o_ard[k], 32'hDEADBEEF);
    end

    // Reset while a read is in flight
    step(mk(1'b1, 1'b1, 1'b1, 16'h0010, 32'hCAFEF00D, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, GA, GA));
    step(mk(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, GA, GA));
    mid_reset();
    step(rst_v);
    step(idle_v);
    for (int k = 0; k < 2; k++) begin
      chk("rstread_rvalid", k, o_arv[k], 1'b0);
      chk("rstread_rdata", k, o_ard[k], 32'h0);
    end
    chk("rstread_owner_idle", 1, inst[1].dut.owner_r, 2'd0);

    // Continuous contention: fixed priority gives B every 5th slot, round-robin alternates
    tbl.push_back(rst_v);
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0,
                       (i % 5 == 4) ? GB : GA, (i % 2 == 0) ? GA : GB));
    // B burst with lock; A forced in after four lost cycles; B resumes once A drops
    tbl.push_back(rst_v);
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0021, 32'h0, 1'b1, 1'b0, 16'h0031, 32'h0, 1'b1, 1'b0, GB, GB));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0021, 32'h0, 1'b1, 1'b0, 16'h0031, 32'h0, 1'b1, 1'b0, GB, GB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0021, 32'h0, 1'b1, 1'b0, 16'h0031, 32'h0, 1'b1, 1'b0, GA, GA));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0021, 32'h0, 1'b1, 1'b0, 16'h0031, 32'h0, 1'b1, 1'b0, GB, GB));
    // Two miss cycles on an A write with B waiting; counters must not move during the miss
    tbl.push_back(rst_v);
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0008, 32'h12345678, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b1, GN, GN));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0008, 32'h12345678, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GA, GA));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GA, GB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GA, GA));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GA, GB));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, GB, GA));

    foreach (tbl[i]) step(tbl[i]);
    step(idle_v);

    chk("miss_write_count", 0, inst[0].wcnt8, 1);
    chk("miss_write_count", 1, inst[1].wcnt8, 1);
    chk("miss_write_data", 0, inst[0].ram[8], 32'h12345678);
    chk("miss_write_data", 1, inst[1].ram[8], 32'h12345678);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      r.rst     = ($urandom_range(0, 199) != 0);
      r.a_req   = ($urandom_range(0, 3) != 0);
      r.a_rw    = 1'($urandom_range(0, 1));
      r.a_addr  = 16'($urandom_range(0, 15));
      r.a_wdata = $urandom();
      r.b_req   = ($urandom_range(0, 3) != 0);
      r.b_rw    = 1'($urandom_range(0, 1));
      r.b_addr  = 16'($urandom_range(0, 15));
      r.b_wdata = $urandom();
      r.b_lock  = ($urandom_range(0, 2) == 0);
      r.miss    = ($urandom_range(0, 7) == 0);
      r.chk     = 1'b0;
      r.g0      = GN;
      r.g1      = GN;
      step(r);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
